// File: rtl/usb_conv_bridge.sv
// usb_conv_bridge: FX2 slave-FIFO EP2->EP6 bridge with loopback or strided/dilated signed FIR; define USB_CONV_SAT_EN to saturate FIR results
module usb_conv_bridge #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_WORDS  = 256,
   parameter int TAPS       = 5,
   parameter int COEF_WIDTH = 4,
   parameter int STRIDE     = 4,
   parameter int DILATION   = 2
) (
   input  logic                         i_usb_ifclk,
   input  logic                         i_rst_n,
   input  logic                         i_usb_flaga,
   input  logic                         i_usb_flagd,
   inout  wire  [DATA_WIDTH-1:0]        io_usb_data,
   output logic [1:0]                   o_usb_addr,
   output logic                         o_usb_slrd,
   output logic                         o_usb_slwr,
   output logic                         o_usb_sloe,
   output logic                         o_usb_pkend,
   input  logic                         i_mode,
   input  logic [TAPS*COEF_WIDTH-1:0]   i_coef,
   output logic                         o_busy,
   output logic                         o_done
);
   localparam int AW   = $clog2(MAX_WORDS);
   localparam int NW   = AW + 1;
   localparam int SPAN = (TAPS - 1) * DILATION + 1;
   localparam int IW   = $clog2(MAX_WORDS + STRIDE + SPAN) + 1;
   localparam int TW   = $clog2(TAPS) + 1;
   localparam int ACCW = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS) + 1;

   typedef enum logic [2:0] {S_IDLE, S_SEL_RD, S_READ, S_CALC, S_SEL_WR, S_WRITE, S_PKEND} state_t;
   state_t r_state, w_next;

   logic [DATA_WIDTH-1:0]        r_buf [MAX_WORDS];
   logic [NW-1:0]                r_n;
   logic                         r_ph, r_wph, r_mode, r_done;
   logic [TAPS*COEF_WIDTH-1:0]   r_coef;
   logic [TW-1:0]                r_t;
   logic [IW-1:0]                r_j, r_k, r_base, r_off;
   logic signed [ACCW-1:0]       r_acc, w_acc, w_cx, w_sx;
   logic signed [COEF_WIDTH-1:0] w_c;
   logic [AW-1:0]                w_idx;
   logic [IW-1:0]                w_nout;
   logic [DATA_WIDTH-1:0]        w_res;
   logic                         w_fit, w_last, w_cap, w_mac;

   // results overwrite the buffer in place: output j only lands below every index still to be read
   assign w_idx  = AW'(r_base + r_off);
   assign w_c    = r_coef[r_t*COEF_WIDTH +: COEF_WIDTH];
   assign w_cx   = ACCW'(w_c);
   assign w_sx   = ACCW'(r_buf[w_idx]);
   assign w_acc  = r_acc + w_cx * w_sx;
   assign w_fit  = (r_base + IW'(SPAN)) <= IW'(r_n);
   assign w_last = r_t == TW'(TAPS - 1);
   assign w_mac  = r_state == S_CALC && (r_t != '0 || w_fit);
   assign w_cap  = r_state == S_READ && r_ph && i_usb_flaga;
   assign w_nout = r_mode ? r_j : IW'(r_n);
   assign io_usb_data = o_usb_sloe ? r_buf[AW'(r_k)] : 'z;

`ifdef USB_CONV_SAT_EN
   assign w_res = w_acc[ACCW-1] ? '0 : (|w_acc[ACCW-2:DATA_WIDTH] ? '1 : w_acc[DATA_WIDTH-1:0]);
`else
   assign w_res = w_acc[DATA_WIDTH-1:0];
`endif

   always_ff @(posedge i_usb_ifclk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = i_usb_flaga ? S_SEL_RD : S_IDLE;
         S_SEL_RD: w_next = S_READ;
         S_READ:   if (!r_ph && (!i_usb_flaga || r_n == NW'(MAX_WORDS))) w_next = r_mode ? S_CALC : S_SEL_WR;
         S_CALC:   if (r_t == '0 && !w_fit) w_next = S_SEL_WR;
         S_SEL_WR: w_next = S_WRITE;
         S_WRITE:  if (!r_wph && r_k == w_nout) w_next = S_PKEND;
         S_PKEND:  if (i_usb_flagd) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_usb_slrd  = !(r_state == S_READ && r_ph);
      o_usb_slwr  = !(r_state == S_WRITE && r_wph && i_usb_flagd);
      o_usb_pkend = !(r_state == S_PKEND && i_usb_flagd);
      o_usb_sloe  = !(r_state == S_SEL_RD || r_state == S_READ);
      o_usb_addr  = (r_state == S_SEL_WR || r_state == S_WRITE || r_state == S_PKEND) ? 2'b10 : 2'b00;
      o_busy      = r_state != S_IDLE;
      o_done      = r_done;
   end

   always_ff @(posedge i_usb_ifclk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_n    <= '0;
         r_ph   <= 1'b0;
         r_wph  <= 1'b0;
         r_mode <= 1'b0;
         r_done <= 1'b0;
         r_coef <= '0;
         r_t    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_base <= '0;
         r_off  <= '0;
         r_acc  <= '0;
      end else begin
         r_ph   <= r_state == S_READ && !r_ph;
         r_done <= r_state == S_PKEND && i_usb_flagd;
         if (r_state == S_IDLE) begin
            r_n    <= '0;
            r_wph  <= 1'b0;
            r_t    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_base <= '0;
            r_off  <= '0;
            r_acc  <= '0;
            if (i_usb_flaga) begin
               r_mode <= i_mode;
               r_coef <= i_coef;
            end
         end
         if (w_cap) r_n <= r_n + 1'b1;
         if (w_mac) begin
            r_t   <= w_last ? '0 : r_t + 1'b1;
            r_off <= w_last ? '0 : r_off + IW'(DILATION);
            r_acc <= w_last ? '0 : w_acc;
            if (w_last) begin
               r_j    <= r_j + 1'b1;
               r_base <= r_base + IW'(STRIDE);
            end
         end
         if (r_state == S_WRITE) begin
            if (!r_wph) r_wph <= r_k != w_nout;
            else if (i_usb_flagd) begin
               r_wph <= 1'b0;
               r_k   <= r_k + 1'b1;
            end
         end
      end

   always_ff @(posedge i_usb_ifclk)
      if (w_cap) r_buf[r_n[AW-1:0]] <= io_usb_data;
      else if (w_mac && w_last) r_buf[r_j[AW-1:0]] <= w_res;
endmodule

// File: tb/tb_usb_conv_bridge.sv
// tb_usb_conv_bridge: FX2 FIFO model driving usb_conv_bridge, with an EP6 scoreboard of expected words and packet ends
module tb_usb_conv_bridge;
   localparam int DW = 16;
   localparam int CB = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flaga, flagd = 1'b1;
   logic          i_mode = 1'b0;
   logic [CB-1:0] i_coef = '0;
   logic [1:0]    addr;
   logic          slrd, slwr, sloe, pkend, busy, done;
   wire  [DW-1:0] usb_data;

   logic [DW-1:0] mem [1024];
   int            len = 0, idx = 0, checks = 0, errors = 0, rx_words = 0;
   logic [16:0]   exp_q [$];
   logic [16:0]   mon_e;

   usb_conv_bridge dut (
      .i_usb_ifclk(clk), .i_rst_n(rst_n), .i_usb_flaga(flaga), .i_usb_flagd(flagd),
      .io_usb_data(usb_data), .o_usb_addr(addr), .o_usb_slrd(slrd), .o_usb_slwr(slwr),
      .o_usb_sloe(sloe), .o_usb_pkend(pkend), .i_mode(i_mode), .i_coef(i_coef),
      .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   assign flaga    = idx < len;
   assign usb_data = sloe ? 'z : mem[idx[9:0]];

   always @(posedge clk) if (!slrd && flaga) idx <= idx + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // EP6 side: every strobe pops the scoreboard; bit 16 marks a packet end
   always @(negedge clk) if (rst_n) begin
      if (!slrd && !slwr) chk("strobe_overlap", 32'(slwr), 32'd1);
      if (!slwr) begin
         mon_e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1DEAD;
         chk("ep6_word", {16'b0, usb_data}, {15'b0, mon_e});
         rx_words++;
      end
      if (!pkend) begin
         mon_e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1DEAD;
         chk("ep6_pkend", 32'h10000, {15'b0, mon_e});
      end
   end

   function automatic logic [DW-1:0] wd(input int i, input int kind);
      case (kind)
         0:       return DW'(i + 1);
         1:       return DW'(i);
         2:       return 16'd5;
         3:       return 16'hFFFF;
         default: return DW'(i + 100);
      endcase
   endfunction

   task automatic push(input logic [DW-1:0] v);
      exp_q.push_back({1'b0, v});
   endtask

   task automatic push_end();
      exp_q.push_back(17'h10000);
   endtask

   task automatic pkt(input logic mode, input logic [CB-1:0] coef, input int n, input int kind, input bit scr);
      int c = 0;
      i_mode = mode;
      i_coef = coef;
      for (int i = 0; i < n; i++) begin
         mem[len[9:0]] = wd(i, kind);
         len++;
      end
      if (scr) begin
         while (!busy && c < 200) begin @(negedge clk); c++; end
         chk("busy_rise", 32'(busy), 32'd1);
         i_mode = ~mode;
         i_coef = ~coef;
      end
   endtask

   task automatic wait_done(input string name, input int rem);
      int c = 0;
      do begin @(negedge clk); c++; end while (!done && c < 3000);
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_drain"}, exp_q.size(), rem);
   endtask

   task automatic wait_rx(input int target);
      int c = 0;
      while (rx_words < target && c < 2000) begin @(negedge clk); c++; end
      chk("wait_rx", 32'(rx_words >= target), 32'd1);
   endtask

   initial begin
      int b;
      #1 rst_n = 1'b0;
      #1 chk("reset_outputs", {24'b0, slrd, slwr, pkend, sloe, addr, busy, done}, 32'b1111_0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i <= 8; i++) push(DW'(i));
      push_end();
      pkt(1'b0, '0, 8, 0, 1'b1);
      wait_done("t1_loop", 0);

      push(16'd20); push(16'd40); push(16'd60); push_end();
      pkt(1'b1, {5{4'h1}}, 20, 1, 1'b1);
      wait_done("t2_conv20", 0);

      push(16'd20); push(16'd40); push(16'd60); push(16'd80); push_end();
      pkt(1'b1, {5{4'h1}}, 21, 1, 1'b1);
      wait_done("t2_conv21", 0);

      push_end();
      pkt(1'b1, {5{4'h1}}, 8, 1, 1'b1);
      wait_done("t3_zlp", 0);

`ifdef USB_CONV_SAT_EN
      push(16'h0000);
`else
      push(16'hFFFB);
`endif
      push_end();
      pkt(1'b1, 20'h0000F, 9, 2, 1'b1);
      wait_done("t5_neg", 0);

`ifdef USB_CONV_SAT_EN
      push(16'hFFFF);
`else
      push(16'hFFDD);
`endif
      push_end();
      pkt(1'b1, {5{4'h7}}, 9, 3, 1'b1);
      wait_done("t5_ovf", 0);

      b = rx_words;
      for (int i = 1; i <= 6; i++) push(DW'(i));
      push_end();
      pkt(1'b0, '0, 6, 0, 1'b1);
      wait_rx(b + 3);
      flagd = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("stall_slwr", 32'(slwr), 32'd1);
      end
      flagd = 1'b1;
      wait_done("t4_stall", 0);

      for (int i = 0; i < 256; i++) push(DW'(i + 100));
      push_end();
      push(16'd356); push(16'd357); push_end();
      pkt(1'b0, '0, 258, 4, 1'b0);
      wait_done("max_first", 3);
      wait_done("max_rest", 0);

      pkt(1'b0, '0, 40, 0, 1'b0);
      b = 0;
      while (idx < len - 30 && b < 500) begin @(negedge clk); b++; end
      @(negedge clk);
      chk("busy_before_rst_read", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1 chk("rst_mid_read", {28'b0, slrd, slwr, pkend, busy}, 32'b1110);
      len = idx;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      push(16'd20); push(16'd40); push(16'd60); push_end();
      pkt(1'b1, {5{4'h1}}, 20, 1, 1'b1);
      wait_done("after_rst_read", 0);

      b = rx_words;
      for (int i = 1; i <= 10; i++) push(DW'(i));
      push_end();
      pkt(1'b0, '0, 10, 0, 1'b1);
      wait_rx(b + 2);
      chk("busy_before_rst_write", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1 chk("rst_mid_write", {28'b0, slrd, slwr, pkend, busy}, 32'b1110);
      exp_q.delete();
      len = idx;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i <= 8; i++) push(DW'(i));
      push_end();
      pkt(1'b0, '0, 8, 0, 1'b1);
      wait_done("after_rst_write", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
